charlie_scan_sequencer: RTL and testbench

Generates the scan sequence for the charlieplex LED driver: which LED index is lit, which frame of the register-backed frame buffer is shown, and when the driver must blank between LEDs. It sits directly upstream of the charlie driver and replaces the free-running counter bits as its `charlie_index` and `frame_index` source. Configuration arrives from the SPI read/write register bank.

---
 rtl/charlie_pkg.sv | 19 +
 rtl/scan_dwell_timer.sv | 41 ++++
 rtl/charlie_scan_sequencer.sv | 160 ++++++++++++++++
 tb/tb_charlie_scan_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/charlie_pkg.sv
// Shared definitions for the charlieplex scan sequencer and the charlie driver.
package charlie_pkg;

  // Default geometry of the LED matrix
  localparam int LED_COUNT_DEF = 56;
  localparam int INDEX_W_DEF   = 6;
  localparam int FRAME_W_DEF   = 2;

  // Number of frames in the register-backed frame buffer
  localparam int FRAME_COUNT   = 1 << FRAME_W_DEF;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// 8-bit loadable down-counter shared by the blank and on-time phases.
// Flags zero (terminal count) and one (last blank cycle).
module scan_dwell_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       tc_o,
  output logic       one_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over load, load wins over decrement; never wraps below 0
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o  = (cnt_q == 8'd0);
  assign one_o = (cnt_q == 8'd1);

endmodule

// File: rtl/charlie_scan_sequencer.sv
// Scan sequencer for the charlieplex LED driver: steps the lit LED index,
// inserts blanking between LEDs, and selects the displayed frame.
module charlie_scan_sequencer
  import charlie_pkg::*;
#(
  parameter int LED_COUNT = LED_COUNT_DEF,
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int FRAME_W   = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         dwell,
  input  logic [3:0]         blank,
  input  logic               auto_advance,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic [FRAME_W-1:0] frame_last,
  input  logic [7:0]         frame_hold,
  output logic [INDEX_W-1:0] charlie_index,
  output logic [FRAME_W-1:0] frame_index,
  output logic               led_active,
  output logic               sweep_done,
  output logic               frame_tick
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LED_COUNT - 1);

  scan_state_e        state_q;
  logic [INDEX_W-1:0] index_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic [7:0]         sweep_q;
  logic [7:0]         sweep_d;
  logic               led_q;
  logic               sweep_done_q;
  logic               frame_tick_q;
  logic               frame_tick_d;

  logic       tmr_tc;
  logic       tmr_one;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_clear;
  logic [7:0] tmr_val;
  logic       start;
  logic       running;
  logic       blank_done;
  logic       on_done;
  logic       wrap;

  // Phase-end detection and timer control; dwell/blank are only sampled on a load
  always_comb begin
    start      = (state_q == ST_IDLE) && enable;
    running    = (state_q != ST_IDLE) && enable;
    blank_done = (state_q == ST_BLANK) && tmr_one;
    on_done    = (state_q == ST_ON) && tmr_tc;
    wrap       = running && on_done && (index_q == LAST_IDX);
    tmr_clear  = !enable;
    tmr_load   = start || (running && (blank_done || on_done));
    tmr_dec    = running && !tmr_load;
    tmr_val    = (blank_done || (blank == 4'd0)) ? dwell : {4'd0, blank};
  end

  scan_dwell_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .tc_o       (tmr_tc),
    .one_o      (tmr_one)
  );

  // Frame selection: manual mode follows frame_sel in IDLE and at each wrap,
  // auto mode advances after frame_hold+1 sweeps
  always_comb begin
    frame_d      = frame_q;
    sweep_d      = sweep_q;
    frame_tick_d = 1'b0;
    if (!auto_advance) begin
      sweep_d = '0;
      if ((state_q == ST_IDLE) || wrap) begin
        frame_d = frame_sel;
      end
      frame_tick_d = (frame_d != frame_q);
    end else if (wrap) begin
      if (sweep_q == frame_hold) begin
        sweep_d      = '0;
        frame_d      = (frame_q >= frame_last) ? '0 : frame_q + 1'b1;
        frame_tick_d = 1'b1;
      end else begin
        sweep_d = sweep_q + 8'd1;
      end
    end
    if (!enable) begin
      sweep_d = '0;
    end
  end

  // Scan FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      frame_q      <= '0;
      sweep_q      <= '0;
      led_q        <= 1'b0;
      sweep_done_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_q      <= frame_d;
      sweep_q      <= sweep_d;
      frame_tick_q <= frame_tick_d;
      sweep_done_q <= wrap;
      if (!enable) begin
        state_q <= ST_IDLE;
        led_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (blank != 4'd0) begin
              state_q <= ST_BLANK;
              led_q   <= 1'b0;
            end else begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end
          end
          ST_BLANK: begin
            if (tmr_one) begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end
          end
          ST_ON: begin
            if (tmr_tc) begin
              index_q <= (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
              if (blank != 4'd0) begin
                state_q <= ST_BLANK;
                led_q   <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            led_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign charlie_index = index_q;
  assign frame_index   = frame_q;
  assign led_active    = led_q;
  assign sweep_done    = sweep_done_q;
  assign frame_tick    = frame_tick_q;

endmodule

// File: tb/tb_charlie_scan_sequencer.sv
// Directed bench for charlie_scan_sequencer (LED_COUNT=56).
module tb_charlie_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] dwell;
  logic [3:0] blank;
  logic       auto_advance;
  logic [1:0] frame_sel;
  logic [1:0] frame_last;
  logic [7:0] frame_hold;
  logic [5:0] charlie_index;
  logic [1:0] frame_index;
  logic       led_active;
  logic       sweep_done;
  logic       frame_tick;

  int n_vec  = 0;
  int n_miss = 0;

  charlie_scan_sequencer #(
    .LED_COUNT (56),
    .INDEX_W   (6),
    .FRAME_W   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .dwell         (dwell),
    .blank         (blank),
    .auto_advance  (auto_advance),
    .frame_sel     (frame_sel),
    .frame_last    (frame_last),
    .frame_hold    (frame_hold),
    .charlie_index (charlie_index),
    .frame_index   (frame_index),
    .led_active    (led_active),
    .sweep_done    (sweep_done),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    dwell        = 8'd0;
    blank        = 4'd0;
    auto_advance = 1'b0;
    frame_sel    = 2'd0;
    frame_last   = 2'd0;
    frame_hold   = 8'd0;
    repeat (2) step();

    // reset state
    chk_vec("rst_index", charlie_index, 0);
    chk_vec("rst_frame", frame_index, 0);
    chk_vec("rst_led", led_active, 0);
    chk_vec("rst_sweep", sweep_done, 0);
    chk_vec("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    step();

    // dwell=3, blank=2: 2 dark + 4 lit cycles per LED, index steps every 6
    dwell  = 8'd3;
    blank  = 4'd2;
    enable = 1'b1;
    for (int c = 1; c <= 106; c++) begin
      step();
      if (c <= 13) begin
        chk_vec("a_led", led_active, (((c - 1) % 6) >= 2) ? 1 : 0);
        chk_vec("a_idx", charlie_index, (c - 1) / 6);
      end
    end
    chk_vec("a_idx17", charlie_index, 17);
    chk_vec("a_led17", led_active, 1);

    // asynchronous reset mid-ON, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk_vec("async_idx", charlie_index, 0);
    chk_vec("async_frame", frame_index, 0);
    chk_vec("async_led", led_active, 0);
    chk_vec("async_sweep", sweep_done, 0);
    chk_vec("async_tick", frame_tick, 0);
    enable = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // dwell=0, blank=0: always lit, index every cycle, wrap every 56
    dwell  = 8'd0;
    blank  = 4'd0;
    enable = 1'b1;
    for (int c = 1; c <= 114; c++) begin
      step();
      chk_vec("b_led", led_active, 1);
      chk_vec("b_idx", charlie_index, (c - 1) % 56);
      chk_vec("b_sweep", sweep_done, (c > 1 && ((c - 1) % 56) == 0) ? 1 : 0);
    end
    apply_reset();

    // auto mode: frame_hold=1, frame_last=2 -> frames 0,1,2,0 every 2 sweeps
    auto_advance = 1'b1;
    frame_hold   = 8'd1;
    frame_last   = 2'd2;
    enable       = 1'b1;
    for (int c = 1; c <= 338; c++) begin
      int  wraps;
      bit  w;
      step();
      wraps = (c - 1) / 56;
      w     = (c > 1) && (((c - 1) % 56) == 0);
      chk_vec("c_frame", frame_index, (wraps / 2) % 3);
      chk_vec("c_tick", frame_tick, (w && (wraps % 2) == 0) ? 1 : 0);
      if (w) chk_vec("c_sweep", sweep_done, 1);
    end
    auto_advance = 1'b0;
    apply_reset();

    // manual mode: frame_sel 0->3 mid-sweep takes effect only at the wrap
    frame_sel = 2'd0;
    enable    = 1'b1;
    for (int c = 1; c <= 114; c++) begin
      step();
      chk_vec("d_frame", frame_index, (c >= 57) ? 3 : 0);
      chk_vec("d_tick", frame_tick, (c == 57) ? 1 : 0);
      if (c == 57 || c == 113) chk_vec("d_sweep", sweep_done, 1);
      if (c == 20) frame_sel = 2'd3;
    end
    frame_sel = 2'd0;
    apply_reset();

    // enable dropped mid-ON at index 9, then resumed with full blank + dwell
    dwell  = 8'd3;
    blank  = 4'd2;
    enable = 1'b1;
    for (int c = 1; c <= 58; c++) step();
    chk_vec("e_idx_before", charlie_index, 9);
    chk_vec("e_led_before", led_active, 1);
    enable = 1'b0;
    step();
    chk_vec("e_led_off", led_active, 0);
    chk_vec("e_idx_held", charlie_index, 9);
    repeat (3) step();
    chk_vec("e_led_idle", led_active, 0);
    chk_vec("e_idx_idle", charlie_index, 9);
    enable = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk_vec("e_led", led_active, (c >= 3 && c <= 6) ? 1 : 0);
      chk_vec("e_idx", charlie_index, (c == 7) ? 10 : 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
